// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_gen
// Purpose : Programmable raster timing generator with shadowed timing
//           registers, registered sync/DE/tick outputs and a line-compare IRQ.
// Rev     : 1.0
// ============================================================================
module video_timing_gen #(
   parameter int BITS         = 16,
   parameter int ADDRESS_BITS = 4,
   parameter int COUNT_BITS   = 11
) (
   input  logic                    CLK,
   input  logic                    RSTb,
   input  logic [ADDRESS_BITS-1:0] ADDRESS,
   input  logic [BITS-1:0]         DATA_IN,
   input  logic                    WR,
   output logic [BITS-1:0]         DATA_OUT,
   output logic                    HS,
   output logic                    VS,
   output logic                    DE,
   output logic                    H_TICK,
   output logic                    V_TICK,
   output logic [COUNT_BITS-1:0]   X,
   output logic [COUNT_BITS-1:0]   Y,
   output logic                    LINE_IRQ
);
   localparam int TW = COUNT_BITS + 2;

   function automatic logic [COUNT_BITS-1:0] f_rst_timing(input int idx);
      case (idx)
         0:       return COUNT_BITS'(640);
         1:       return COUNT_BITS'(16);
         2:       return COUNT_BITS'(96);
         3:       return COUNT_BITS'(48);
         4:       return COUNT_BITS'(480);
         5:       return COUNT_BITS'(10);
         6:       return COUNT_BITS'(2);
         default: return COUNT_BITS'(33);
      endcase
   endfunction

   function automatic logic [TW-1:0] f_ext(input logic [COUNT_BITS-1:0] v);
      return {2'b00, v};
   endfunction

   logic [COUNT_BITS-1:0] shadow_q [8];
   logic [COUNT_BITS-1:0] shadow_d [8];
   logic [COUNT_BITS-1:0] active_q [8];
   logic [COUNT_BITS-1:0] active_d [8];
   logic [2:0]            ctrl_q, ctrl_d;
   logic [COUNT_BITS-1:0] line_cmp_q, line_cmp_d;
   logic                  pend_q, pend_d;
   logic [15:0]           frame_q, frame_d;
   logic [TW-1:0]         hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic                  htick_q, htick_d, vtick_q, vtick_d;
   logic [COUNT_BITS-1:0] x_q, x_d, y_q, y_d;
   logic [BITS-1:0]       rdata_q, rdata_d;

   logic          enable, h_last, v_last, frame_wrap, irq_set, irq_clr;
   logic [TW-1:0] h_act, h_sync_start, h_sync_end, h_total;
   logic [TW-1:0] v_act, v_sync_start, v_sync_end, v_total;
   logic          unused_data;

   assign unused_data = ^DATA_IN[BITS-1:COUNT_BITS];
   assign enable      = ctrl_q[0];

   // Active size of zero is clamped to one; zero-length porches/sync simply vanish from the sums.
   assign h_act        = (active_q[0] == '0) ? TW'(1) : f_ext(active_q[0]);
   assign h_sync_start = h_act + f_ext(active_q[1]);
   assign h_sync_end   = h_sync_start + f_ext(active_q[2]);
   assign h_total      = h_sync_end + f_ext(active_q[3]);
   assign v_act        = (active_q[4] == '0) ? TW'(1) : f_ext(active_q[4]);
   assign v_sync_start = v_act + f_ext(active_q[5]);
   assign v_sync_end   = v_sync_start + f_ext(active_q[6]);
   assign v_total      = v_sync_end + f_ext(active_q[7]);

   assign h_last     = hcnt_q >= h_total - TW'(1);
   assign v_last     = vcnt_q >= v_total - TW'(1);
   assign frame_wrap = enable && h_last && v_last;
   assign irq_set    = enable && (hcnt_q == '0) && (vcnt_q == f_ext(line_cmp_q));
   assign irq_clr    = WR && (ADDRESS == ADDRESS_BITS'(10)) && DATA_IN[0];

   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (!enable) begin
         hcnt_d = '0;
         vcnt_d = '0;
      end else if (h_last) begin
         hcnt_d = '0;
         vcnt_d = v_last ? '0 : vcnt_q + TW'(1);
      end else begin
         hcnt_d = hcnt_q + TW'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         shadow_d[i] = shadow_q[i];
         if (WR && (ADDRESS == ADDRESS_BITS'(i)))
            shadow_d[i] = DATA_IN[COUNT_BITS-1:0];
         active_d[i] = (frame_wrap || !enable) ? shadow_q[i] : active_q[i];
      end
      ctrl_d     = (WR && (ADDRESS == ADDRESS_BITS'(8))) ? DATA_IN[2:0] : ctrl_q;
      line_cmp_d = (WR && (ADDRESS == ADDRESS_BITS'(9))) ? DATA_IN[COUNT_BITS-1:0] : line_cmp_q;
      pend_d     = irq_set ? 1'b1 : (irq_clr ? 1'b0 : pend_q);
      frame_d    = frame_wrap ? frame_q + 16'd1 : frame_q;
   end

   always_comb begin
      de_d    = enable && (hcnt_q < h_act) && (vcnt_q < v_act);
      hs_d    = (enable && (hcnt_q >= h_sync_start) && (hcnt_q < h_sync_end)) ? ctrl_q[1] : ~ctrl_q[1];
      vs_d    = (enable && (vcnt_q >= v_sync_start) && (vcnt_q < v_sync_end)) ? ctrl_q[2] : ~ctrl_q[2];
      htick_d = enable && (hcnt_q == '0);
      vtick_d = enable && (hcnt_q == '0) && (vcnt_q == '0);
      x_d     = hcnt_q[COUNT_BITS-1:0];
      y_d     = vcnt_q[COUNT_BITS-1:0];
      rdata_d = '0;
      for (int i = 0; i < 8; i++)
         if (ADDRESS == ADDRESS_BITS'(i)) rdata_d = BITS'(shadow_q[i]);
      if (ADDRESS == ADDRESS_BITS'(8))  rdata_d = BITS'(ctrl_q);
      if (ADDRESS == ADDRESS_BITS'(9))  rdata_d = BITS'(line_cmp_q);
      if (ADDRESS == ADDRESS_BITS'(10)) rdata_d = BITS'(pend_q);
      if (ADDRESS == ADDRESS_BITS'(11)) rdata_d = BITS'(frame_q);
      if (ADDRESS == ADDRESS_BITS'(12)) rdata_d = BITS'(vcnt_q[COUNT_BITS-1:0]);
   end

   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= f_rst_timing(i);
            active_q[i] <= f_rst_timing(i);
         end
         ctrl_q     <= 3'b001;
         line_cmp_q <= '0;
         pend_q     <= 1'b0;
         frame_q    <= '0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         de_q       <= 1'b1;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         htick_q    <= 1'b1;
         vtick_q    <= 1'b1;
         x_q        <= '0;
         y_q        <= '0;
         rdata_q    <= '0;
      end else begin
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         ctrl_q     <= ctrl_d;
         line_cmp_q <= line_cmp_d;
         pend_q     <= pend_d;
         frame_q    <= frame_d;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         de_q       <= de_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         htick_q    <= htick_d;
         vtick_q    <= vtick_d;
         x_q        <= x_d;
         y_q        <= y_d;
         rdata_q    <= rdata_d;
      end
   end

   assign DATA_OUT = rdata_q;
   assign HS       = hs_q;
   assign VS       = vs_q;
   assign DE       = de_q;
   assign H_TICK   = htick_q;
   assign V_TICK   = vtick_q;
   assign X        = x_q;
   assign Y        = y_q;
   assign LINE_IRQ = pend_q;

endmodule
`default_nettype wire
